// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the two-master AXI arbiter.
//   arb_state_t : arbiter FSM state (IDLE / RD / WR)
//   mst_idx_t   : index of a master (0 = I-cache, 1 = LSU)
//   NUM_MST     : number of masters sharing the slave
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t;

  typedef logic mst_idx_t;

  localparam int NUM_MST = 2;

endpackage

// File: rtl/axi_arb2_rr.sv
// rr_arb2: purely combinational two-way master selector.
//   req[1:0] in  : per-master request (arvalid | awvalid)
//   last     in  : master granted most recently
//   grant    out : master to serve next (only meaningful when req != 0)
// Build option AXI_ARB_FIXED_PRIO_EN: master 0 always wins a tie and
// 'last' is ignored; otherwise a tie goes to the master not served last.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [NUM_MST-1:0] req,
  input  mst_idx_t           last,
  output mst_idx_t           grant
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic w_unusedLast;
  assign w_unusedLast = last;
`endif

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b10) begin
      grant = 1'b1;
    end else if (req == 2'b11) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last;
`endif
    end
  end

endmodule

// File: rtl/axi_arb2.sv
// axi_arb2: shares one AXI4 slave between master 0 (I-cache) and master 1
// (LSU), serialising whole transactions: one read burst or one write burst
// in flight at a time. Tie policy is round-robin, or fixed priority for
// master 0 when built with AXI_ARB_FIXED_PRIO_EN (see rr_arb2).
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   m0_axi_*         : master 0 AW/W/B/AR/R channels (slave-facing view)
//   m1_axi_*         : master 1, same set as m0_axi_*
//   s_axi_*          : toward the shared slave, directions reversed
// Parameters: CPU_WIDTH (address/data width), ID_WIDTH (passed through).
module axi_arb2
  import axi_arb_pkg::*;
#(
  parameter int CPU_WIDTH = 32,
  parameter int ID_WIDTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   m0_axi_awvalid,
  input  logic [CPU_WIDTH-1:0]   m0_axi_awaddr,
  input  logic [ID_WIDTH-1:0]    m0_axi_awid,
  input  logic [7:0]             m0_axi_awlen,
  input  logic [2:0]             m0_axi_awsize,
  input  logic [1:0]             m0_axi_awburst,
  output logic                   m0_axi_awready,
  input  logic                   m0_axi_wvalid,
  input  logic [CPU_WIDTH-1:0]   m0_axi_wdata,
  input  logic [CPU_WIDTH/8-1:0] m0_axi_wstrb,
  input  logic                   m0_axi_wlast,
  output logic                   m0_axi_wready,
  output logic                   m0_axi_bvalid,
  output logic [1:0]             m0_axi_bresp,
  output logic [ID_WIDTH-1:0]    m0_axi_bid,
  input  logic                   m0_axi_bready,
  input  logic                   m0_axi_arvalid,
  input  logic [CPU_WIDTH-1:0]   m0_axi_araddr,
  input  logic [ID_WIDTH-1:0]    m0_axi_arid,
  input  logic [7:0]             m0_axi_arlen,
  input  logic [2:0]             m0_axi_arsize,
  input  logic [1:0]             m0_axi_arburst,
  output logic                   m0_axi_arready,
  output logic                   m0_axi_rvalid,
  output logic [1:0]             m0_axi_rresp,
  output logic [CPU_WIDTH-1:0]   m0_axi_rdata,
  output logic                   m0_axi_rlast,
  output logic [ID_WIDTH-1:0]    m0_axi_rid,
  input  logic                   m0_axi_rready,
  input  logic                   m1_axi_awvalid,
  input  logic [CPU_WIDTH-1:0]   m1_axi_awaddr,
  input  logic [ID_WIDTH-1:0]    m1_axi_awid,
  input  logic [7:0]             m1_axi_awlen,
  input  logic [2:0]             m1_axi_awsize,
  input  logic [1:0]             m1_axi_awburst,
  output logic                   m1_axi_awready,
  input  logic                   m1_axi_wvalid,
  input  logic [CPU_WIDTH-1:0]   m1_axi_wdata,
  input  logic [CPU_WIDTH/8-1:0] m1_axi_wstrb,
  input  logic                   m1_axi_wlast,
  output logic                   m1_axi_wready,
  output logic                   m1_axi_bvalid,
  output logic [1:0]             m1_axi_bresp,
  output logic [ID_WIDTH-1:0]    m1_axi_bid,
  input  logic                   m1_axi_bready,
  input  logic                   m1_axi_arvalid,
  input  logic [CPU_WIDTH-1:0]   m1_axi_araddr,
  input  logic [ID_WIDTH-1:0]    m1_axi_arid,
  input  logic [7:0]             m1_axi_arlen,
  input  logic [2:0]             m1_axi_arsize,
  input  logic [1:0]             m1_axi_arburst,
  output logic                   m1_axi_arready,
  output logic                   m1_axi_rvalid,
  output logic [1:0]             m1_axi_rresp,
  output logic [CPU_WIDTH-1:0]   m1_axi_rdata,
  output logic                   m1_axi_rlast,
  output logic [ID_WIDTH-1:0]    m1_axi_rid,
  input  logic                   m1_axi_rready,
  output logic                   s_axi_awvalid,
  output logic [CPU_WIDTH-1:0]   s_axi_awaddr,
  output logic [ID_WIDTH-1:0]    s_axi_awid,
  output logic [7:0]             s_axi_awlen,
  output logic [2:0]             s_axi_awsize,
  output logic [1:0]             s_axi_awburst,
  input  logic                   s_axi_awready,
  output logic                   s_axi_wvalid,
  output logic [CPU_WIDTH-1:0]   s_axi_wdata,
  output logic [CPU_WIDTH/8-1:0] s_axi_wstrb,
  output logic                   s_axi_wlast,
  input  logic                   s_axi_wready,
  input  logic                   s_axi_bvalid,
  input  logic [1:0]             s_axi_bresp,
  input  logic [ID_WIDTH-1:0]    s_axi_bid,
  output logic                   s_axi_bready,
  output logic                   s_axi_arvalid,
  output logic [CPU_WIDTH-1:0]   s_axi_araddr,
  output logic [ID_WIDTH-1:0]    s_axi_arid,
  output logic [7:0]             s_axi_arlen,
  output logic [2:0]             s_axi_arsize,
  output logic [1:0]             s_axi_arburst,
  input  logic                   s_axi_arready,
  input  logic                   s_axi_rvalid,
  input  logic [1:0]             s_axi_rresp,
  input  logic [CPU_WIDTH-1:0]   s_axi_rdata,
  input  logic                   s_axi_rlast,
  input  logic [ID_WIDTH-1:0]    s_axi_rid,
  output logic                   s_axi_rready
);

  arb_state_t       r_state;
  mst_idx_t         r_grant;
  mst_idx_t         r_last;
  logic             r_addrDone;

  logic [NUM_MST-1:0] w_req;
  mst_idx_t         w_pick;
  logic             w_pickAr;
  logic             w_rdAct, w_wrAct;
  logic             w_rd0, w_rd1, w_wr0, w_wr1;

  assign w_req    = {m1_axi_arvalid | m1_axi_awvalid, m0_axi_arvalid | m0_axi_awvalid};
  assign w_pickAr = w_pick ? m1_axi_arvalid : m0_axi_arvalid;

  rr_arb2 u_sel (
    .req   (w_req),
    .last  (r_last),
    .grant (w_pick)
  );

  // Requests are only looked at in IDLE; a transaction ends on the final
  // R beat or the B handshake, and r_addrDone blocks a second AR/AW
  // handshake from the granted master within the same transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_addrDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant    <= w_pick;
            r_addrDone <= 1'b0;
            r_state    <= w_pickAr ? RD : WR;
          end
        end
        RD: begin
          if (s_axi_arvalid && s_axi_arready) r_addrDone <= 1'b1;
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
            r_state <= IDLE;
            r_last  <= r_grant;
          end
        end
        WR: begin
          if (s_axi_awvalid && s_axi_awready) r_addrDone <= 1'b1;
          if (s_axi_bvalid && s_axi_bready) begin
            r_state <= IDLE;
            r_last  <= r_grant;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rdAct = (r_state == RD);
  assign w_wrAct = (r_state == WR);
  assign w_rd0   = w_rdAct & ~r_grant;
  assign w_rd1   = w_rdAct &  r_grant;
  assign w_wr0   = w_wrAct & ~r_grant;
  assign w_wr1   = w_wrAct &  r_grant;

  // Slave-side read path: everything zero unless a read is granted.
  assign s_axi_arvalid = w_rdAct & ~r_addrDone & (r_grant ? m1_axi_arvalid : m0_axi_arvalid);
  assign s_axi_araddr  = w_rdAct ? (r_grant ? m1_axi_araddr  : m0_axi_araddr)  : '0;
  assign s_axi_arid    = w_rdAct ? (r_grant ? m1_axi_arid    : m0_axi_arid)    : '0;
  assign s_axi_arlen   = w_rdAct ? (r_grant ? m1_axi_arlen   : m0_axi_arlen)   : '0;
  assign s_axi_arsize  = w_rdAct ? (r_grant ? m1_axi_arsize  : m0_axi_arsize)  : '0;
  assign s_axi_arburst = w_rdAct ? (r_grant ? m1_axi_arburst : m0_axi_arburst) : '0;
  assign s_axi_rready  = w_rdAct & (r_grant ? m1_axi_rready : m0_axi_rready);

  // Slave-side write path: W may run ahead of or behind AW within WR.
  assign s_axi_awvalid = w_wrAct & ~r_addrDone & (r_grant ? m1_axi_awvalid : m0_axi_awvalid);
  assign s_axi_awaddr  = w_wrAct ? (r_grant ? m1_axi_awaddr  : m0_axi_awaddr)  : '0;
  assign s_axi_awid    = w_wrAct ? (r_grant ? m1_axi_awid    : m0_axi_awid)    : '0;
  assign s_axi_awlen   = w_wrAct ? (r_grant ? m1_axi_awlen   : m0_axi_awlen)   : '0;
  assign s_axi_awsize  = w_wrAct ? (r_grant ? m1_axi_awsize  : m0_axi_awsize)  : '0;
  assign s_axi_awburst = w_wrAct ? (r_grant ? m1_axi_awburst : m0_axi_awburst) : '0;
  assign s_axi_wvalid  = w_wrAct & (r_grant ? m1_axi_wvalid : m0_axi_wvalid);
  assign s_axi_wdata   = w_wrAct ? (r_grant ? m1_axi_wdata : m0_axi_wdata) : '0;
  assign s_axi_wstrb   = w_wrAct ? (r_grant ? m1_axi_wstrb : m0_axi_wstrb) : '0;
  assign s_axi_wlast   = w_wrAct & (r_grant ? m1_axi_wlast : m0_axi_wlast);
  assign s_axi_bready  = w_wrAct & (r_grant ? m1_axi_bready : m0_axi_bready);

  // Master-side returns: only the granted master sees slave responses.
  assign m0_axi_arready = w_rd0 & ~r_addrDone & s_axi_arready;
  assign m0_axi_rvalid  = w_rd0 & s_axi_rvalid;
  assign m0_axi_rresp   = w_rd0 ? s_axi_rresp : '0;
  assign m0_axi_rdata   = w_rd0 ? s_axi_rdata : '0;
  assign m0_axi_rlast   = w_rd0 & s_axi_rlast;
  assign m0_axi_rid     = w_rd0 ? s_axi_rid : '0;
  assign m0_axi_awready = w_wr0 & ~r_addrDone & s_axi_awready;
  assign m0_axi_wready  = w_wr0 & s_axi_wready;
  assign m0_axi_bvalid  = w_wr0 & s_axi_bvalid;
  assign m0_axi_bresp   = w_wr0 ? s_axi_bresp : '0;
  assign m0_axi_bid     = w_wr0 ? s_axi_bid : '0;

  assign m1_axi_arready = w_rd1 & ~r_addrDone & s_axi_arready;
  assign m1_axi_rvalid  = w_rd1 & s_axi_rvalid;
  assign m1_axi_rresp   = w_rd1 ? s_axi_rresp : '0;
  assign m1_axi_rdata   = w_rd1 ? s_axi_rdata : '0;
  assign m1_axi_rlast   = w_rd1 & s_axi_rlast;
  assign m1_axi_rid     = w_rd1 ? s_axi_rid : '0;
  assign m1_axi_awready = w_wr1 & ~r_addrDone & s_axi_awready;
  assign m1_axi_wready  = w_wr1 & s_axi_wready;
  assign m1_axi_bvalid  = w_wr1 & s_axi_bvalid;
  assign m1_axi_bresp   = w_wr1 ? s_axi_bresp : '0;
  assign m1_axi_bid     = w_wr1 ? s_axi_bid : '0;

endmodule

// File: tb/tb_axi_arb2.sv
// tb_axi_arb2: directed bench for axi_arb2 with a small behavioural AXI RAM
// (64 words, mem[j] = j after reset) as the shared slave. Expected R/B
// responses are queued when a transaction is launched and compared, in
// global order, when a master sees the response.
// Build option AXI_ARB_FIXED_PRIO_EN switches the expected tie winner.
module tb_axi_arb2;

  localparam int CW = 32;
  localparam int IW = 4;
`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock;
  logic reset;

  logic          mAwvalid[2], mAwready[2], mWvalid[2], mWlast[2], mWready[2];
  logic [CW-1:0] mAwaddr[2], mWdata[2], mAraddr[2], mRdata[2];
  logic [IW-1:0] mAwid[2], mBid[2], mArid[2], mRid[2];
  logic [7:0]    mAwlen[2], mArlen[2];
  logic [2:0]    mAwsize[2], mArsize[2];
  logic [1:0]    mAwburst[2], mArburst[2], mBresp[2], mRresp[2];
  logic [3:0]    mWstrb[2];
  logic          mBvalid[2], mBready[2], mArvalid[2], mArready[2];
  logic          mRvalid[2], mRlast[2], mRready[2];

  logic          sAwvalid, sAwready, sWvalid, sWlast, sWready, sBvalid, sBready;
  logic          sArvalid, sArready, sRvalid, sRlast, sRready;
  logic [CW-1:0] sAwaddr, sWdata, sAraddr, sRdata;
  logic [IW-1:0] sAwid, sBid, sArid, sRid;
  logic [7:0]    sAwlen, sArlen;
  logic [2:0]    sAwsize, sArsize;
  logic [1:0]    sAwburst, sArburst, sBresp, sRresp;
  logic [3:0]    sWstrb;

  axi_arb2 #(.CPU_WIDTH(CW), .ID_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .m0_axi_awvalid(mAwvalid[0]), .m0_axi_awaddr(mAwaddr[0]), .m0_axi_awid(mAwid[0]),
    .m0_axi_awlen(mAwlen[0]), .m0_axi_awsize(mAwsize[0]), .m0_axi_awburst(mAwburst[0]),
    .m0_axi_awready(mAwready[0]),
    .m0_axi_wvalid(mWvalid[0]), .m0_axi_wdata(mWdata[0]), .m0_axi_wstrb(mWstrb[0]),
    .m0_axi_wlast(mWlast[0]), .m0_axi_wready(mWready[0]),
    .m0_axi_bvalid(mBvalid[0]), .m0_axi_bresp(mBresp[0]), .m0_axi_bid(mBid[0]),
    .m0_axi_bready(mBready[0]),
    .m0_axi_arvalid(mArvalid[0]), .m0_axi_araddr(mAraddr[0]), .m0_axi_arid(mArid[0]),
    .m0_axi_arlen(mArlen[0]), .m0_axi_arsize(mArsize[0]), .m0_axi_arburst(mArburst[0]),
    .m0_axi_arready(mArready[0]),
    .m0_axi_rvalid(mRvalid[0]), .m0_axi_rresp(mRresp[0]), .m0_axi_rdata(mRdata[0]),
    .m0_axi_rlast(mRlast[0]), .m0_axi_rid(mRid[0]), .m0_axi_rready(mRready[0]),
    .m1_axi_awvalid(mAwvalid[1]), .m1_axi_awaddr(mAwaddr[1]), .m1_axi_awid(mAwid[1]),
    .m1_axi_awlen(mAwlen[1]), .m1_axi_awsize(mAwsize[1]), .m1_axi_awburst(mAwburst[1]),
    .m1_axi_awready(mAwready[1]),
    .m1_axi_wvalid(mWvalid[1]), .m1_axi_wdata(mWdata[1]), .m1_axi_wstrb(mWstrb[1]),
    .m1_axi_wlast(mWlast[1]), .m1_axi_wready(mWready[1]),
    .m1_axi_bvalid(mBvalid[1]), .m1_axi_bresp(mBresp[1]), .m1_axi_bid(mBid[1]),
    .m1_axi_bready(mBready[1]),
    .m1_axi_arvalid(mArvalid[1]), .m1_axi_araddr(mAraddr[1]), .m1_axi_arid(mArid[1]),
    .m1_axi_arlen(mArlen[1]), .m1_axi_arsize(mArsize[1]), .m1_axi_arburst(mArburst[1]),
    .m1_axi_arready(mArready[1]),
    .m1_axi_rvalid(mRvalid[1]), .m1_axi_rresp(mRresp[1]), .m1_axi_rdata(mRdata[1]),
    .m1_axi_rlast(mRlast[1]), .m1_axi_rid(mRid[1]), .m1_axi_rready(mRready[1]),
    .s_axi_awvalid(sAwvalid), .s_axi_awaddr(sAwaddr), .s_axi_awid(sAwid),
    .s_axi_awlen(sAwlen), .s_axi_awsize(sAwsize), .s_axi_awburst(sAwburst),
    .s_axi_awready(sAwready),
    .s_axi_wvalid(sWvalid), .s_axi_wdata(sWdata), .s_axi_wstrb(sWstrb),
    .s_axi_wlast(sWlast), .s_axi_wready(sWready),
    .s_axi_bvalid(sBvalid), .s_axi_bresp(sBresp), .s_axi_bid(sBid), .s_axi_bready(sBready),
    .s_axi_arvalid(sArvalid), .s_axi_araddr(sAraddr), .s_axi_arid(sArid),
    .s_axi_arlen(sArlen), .s_axi_arsize(sArsize), .s_axi_arburst(sArburst),
    .s_axi_arready(sArready),
    .s_axi_rvalid(sRvalid), .s_axi_rresp(sRresp), .s_axi_rdata(sRdata),
    .s_axi_rlast(sRlast), .s_axi_rid(sRid), .s_axi_rready(sRready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural slave RAM: word addressed by addr[7:2], INCR reads,
  // single-beat writes with byte strobes; contents reload on reset.
  logic [CW-1:0] mem [64];
  logic          rdBusy, awGot, wGot, bPend;
  logic [5:0]    rdPtr, wrAddr;
  logic [7:0]    rdCnt, rdLen;
  logic [IW-1:0] rdId, wrId;
  logic [CW-1:0] wrData;
  logic [3:0]    wrStrb;

  always @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < 64; j++) mem[j] <= 32'(j);
      rdBusy <= 1'b0; awGot <= 1'b0; wGot <= 1'b0; bPend <= 1'b0;
      rdPtr <= '0; rdCnt <= '0; rdLen <= '0; rdId <= '0;
      wrAddr <= '0; wrId <= '0; wrData <= '0; wrStrb <= '0;
    end else begin
      if (sArvalid && sArready) begin
        rdBusy <= 1'b1; rdPtr <= sAraddr[7:2]; rdCnt <= '0; rdLen <= sArlen; rdId <= sArid;
      end
      if (sRvalid && sRready) begin
        if (sRlast) rdBusy <= 1'b0;
        else rdCnt <= rdCnt + 8'd1;
      end
      if (sAwvalid && sAwready) begin
        awGot <= 1'b1; wrAddr <= sAwaddr[7:2]; wrId <= sAwid;
      end
      if (sWvalid && sWready) begin
        wrData <= sWdata; wrStrb <= sWstrb;
        if (sWlast) wGot <= 1'b1;
      end
      if (awGot && wGot && !bPend) begin
        for (int b = 0; b < 4; b++)
          if (wrStrb[b]) mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
        bPend <= 1'b1;
      end
      if (bPend && sBready) begin
        bPend <= 1'b0; awGot <= 1'b0; wGot <= 1'b0;
      end
    end
  end

  assign sArready = !rdBusy;
  assign sRvalid  = rdBusy;
  assign sRdata   = mem[rdPtr + rdCnt[5:0]];
  assign sRlast   = (rdCnt == rdLen);
  assign sRid     = rdId;
  assign sRresp   = 2'b00;
  assign sAwready = !awGot && !bPend;
  assign sWready  = !wGot && !bPend;
  assign sBvalid  = bPend;
  assign sBresp   = 2'b00;
  assign sBid     = wrId;

  // OR of every DUT output; must be zero whenever the arbiter is idle/reset.
  logic anyOut;
  assign anyOut = |{mAwready[0], mWready[0], mBvalid[0], mBresp[0], mBid[0], mArready[0],
                    mRvalid[0], mRresp[0], mRdata[0], mRlast[0], mRid[0],
                    mAwready[1], mWready[1], mBvalid[1], mBresp[1], mBid[1], mArready[1],
                    mRvalid[1], mRresp[1], mRdata[1], mRlast[1], mRid[1],
                    sAwvalid, sAwaddr, sAwid, sAwlen, sAwsize, sAwburst,
                    sWvalid, sWdata, sWstrb, sWlast, sBready,
                    sArvalid, sAraddr, sArid, sArlen, sArsize, sArburst, sRready};

  typedef struct packed {
    logic          isWr;
    logic          mst;
    logic [IW-1:0] id;
    logic [CW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int arHsCyc[2];
  int rlastCyc[2];
  int m1ActCnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input exp_t obs);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL sbUnderflow: observed %h required no response", obs);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("[TB] FAIL response: observed %h required %h", obs, e);
      end
    end
  endtask

  task automatic pushExp(input logic isWr, input int m, input logic [CW-1:0] data, input logic last);
    exp_t e;
    e.isWr = isWr; e.mst = m[0]; e.id = 4'(m + 1); e.data = data; e.last = last;
    sb.push_back(e);
  endtask

  // Reads of the untouched RAM return the word index.
  task automatic expectRead(input int m, input logic [CW-1:0] addr, input int len);
    for (int k = 0; k <= len; k++) pushExp(1'b0, m, 32'(addr[7:2]) + 32'(k), k == len);
  endtask

  // Response monitor, sampled on the falling edge.
  always @(negedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (mRvalid[m] && mRready[m]) begin
        checkBeat({1'b0, m[0], mRid[m], mRdata[m], mRlast[m]});
        if (mRlast[m]) rlastCyc[m] = cyc;
      end
      if (mBvalid[m] && mBready[m]) checkBeat({1'b1, m[0], mBid[m], {30'b0, mBresp[m]}, 1'b1});
      if (mArvalid[m] && mArready[m]) arHsCyc[m] = cyc;
    end
    if (mArready[1] | mRvalid[1] | mAwready[1] | mWready[1] | mBvalid[1]) m1ActCnt++;
  end

  // Drive one AR and hold it until handshaken; call just after a rising edge.
  task automatic applyStimulus(input int m, input logic [CW-1:0] addr, input logic [7:0] len);
    bit done = 1'b0;
    mArvalid[m] = 1'b1; mAraddr[m] = addr; mArlen[m] = len; mArid[m] = 4'(m + 1);
    mArsize[m] = 3'd2; mArburst[m] = 2'b01;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      done = mArready[m];
      @(posedge clock); #1;
    end
    mArvalid[m] = 1'b0; mAraddr[m] = '0; mArlen[m] = '0; mArid[m] = '0;
    mArsize[m] = '0; mArburst[m] = '0;
    checks++;
    assert (done) else begin
      errors++;
      $error("[TB] FAIL arTimeout m%0d: observed no handshake required handshake", m);
    end
  endtask

  // Single-beat write; W is presented wLead cycles before AW.
  task automatic applyWriteStimulus(input int m, input logic [CW-1:0] addr,
                                    input logic [CW-1:0] data, input int wLead);
    bit awDone = 1'b0, wDone = 1'b0, awHs, wHs;
    mWvalid[m] = 1'b1; mWdata[m] = data; mWstrb[m] = 4'hF; mWlast[m] = 1'b1;
    for (int i = 0; i < wLead; i++) begin @(posedge clock); #1; end
    mAwvalid[m] = 1'b1; mAwaddr[m] = addr; mAwid[m] = 4'(m + 1);
    mAwlen[m] = 8'd0; mAwsize[m] = 3'd2; mAwburst[m] = 2'b01;
    for (int i = 0; i < 200 && !(awDone && wDone); i++) begin
      @(negedge clock);
      awHs = mAwvalid[m] & mAwready[m];
      wHs  = mWvalid[m] & mWready[m];
      @(posedge clock); #1;
      if (awHs) begin awDone = 1'b1; mAwvalid[m] = 1'b0; end
      if (wHs) begin wDone = 1'b1; mWvalid[m] = 1'b0; mWlast[m] = 1'b0; end
    end
    mAwvalid[m] = 1'b0; mWvalid[m] = 1'b0;
    checks++;
    assert (awDone && wDone) else begin
      errors++;
      $error("[TB] FAIL wrTimeout m%0d: observed aw=%0d w=%0d required 1 1", m, awDone, wDone);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clock); n++; end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain: observed %0d outstanding required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, n, m1Base;
    int first;
    for (int m = 0; m < 2; m++) begin
      mAwvalid[m] = 0; mAwaddr[m] = '0; mAwid[m] = '0; mAwlen[m] = '0; mAwsize[m] = '0;
      mAwburst[m] = '0; mWvalid[m] = 0; mWdata[m] = '0; mWstrb[m] = '0; mWlast[m] = 0;
      mBready[m] = 1; mArvalid[m] = 0; mAraddr[m] = '0; mArid[m] = '0; mArlen[m] = '0;
      mArsize[m] = '0; mArburst[m] = '0; mRready[m] = 1;
      arHsCyc[m] = 0; rlastCyc[m] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("resetOutputs", 32'(anyOut), 0);
    @(posedge clock); #1;

    $display("[TB] tie right after reset: master 0 first");
    expectRead(0, 'h10, 0);
    expectRead(1, 'h18, 0);
    fork
      applyStimulus(0, 'h10, 0);
      applyStimulus(1, 'h18, 0);
    join
    waitDrain();

    $display("[TB] master 0 single read, master 1 quiet");
    m1Base = m1ActCnt;
    expectRead(0, 'h10, 0);
    t0 = cyc;
    applyStimulus(0, 'h10, 0);
    checkOutput("grantLatency", 32'(arHsCyc[0] - t0), 1);
    waitDrain();
    checkOutput("m1Quiet", 32'(m1ActCnt - m1Base), 0);

    $display("[TB] master 1 write with W leading AW, then read back");
    pushExp(1'b1, 1, 32'h0, 1'b1);
    applyWriteStimulus(1, 'h20, 32'hDEADBEEF, 2);
    waitDrain();
    pushExp(1'b0, 0, 32'hDEADBEEF, 1'b1);
    applyStimulus(0, 'h20, 0);
    waitDrain();

    $display("[TB] four back-to-back ties");
    for (int k = 0; k < 4; k++) begin
      first = FIXED ? 0 : 1;
      expectRead(first, first == 0 ? 32'(4 * k) : 32'('h40 + 4 * k), 0);
      expectRead(1 - first, first == 0 ? 32'('h40 + 4 * k) : 32'(4 * k), 0);
      fork
        applyStimulus(0, 32'(4 * k), 0);
        applyStimulus(1, 32'('h40 + 4 * k), 0);
      join
      waitDrain();
    end

    $display("[TB] master 0 burst with master 1 waiting");
    expectRead(0, 'h00, 3);
    expectRead(1, 'h0C, 0);
    fork
      applyStimulus(0, 'h00, 3);
      begin
        @(posedge clock); #1;
        applyStimulus(1, 'h0C, 0);
      end
    join
    checkOutput("m1GrantGap", 32'(arHsCyc[1] - rlastCyc[0]), 2);
    waitDrain();

    $display("[TB] master 0 AR and AW together: read first");
    expectRead(0, 'h14, 0);
    pushExp(1'b1, 0, 32'h0, 1'b1);
    fork
      applyStimulus(0, 'h14, 0);
      applyWriteStimulus(0, 'h30, 32'h12345678, 0);
    join
    waitDrain();
    pushExp(1'b0, 0, 32'h12345678, 1'b1);
    applyStimulus(0, 'h30, 0);
    waitDrain();

    $display("[TB] reset during a burst");
    expectRead(0, 'h00, 3);
    applyStimulus(0, 'h00, 3);
    n = 0;
    while (sb.size() > 2 && n < 50) begin @(posedge clock); n++; end
    #1;
    checkOutput("reachedBeat2", 32'(sb.size()), 2);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("resetMidBurst", 32'(anyOut), 0);
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    expectRead(1, 'h04, 0);
    applyStimulus(1, 'h04, 0);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_arb2.md
# axi_arb2

Two-master AXI4 arbiter that shares one AXI slave (the `axi_ram` behind the I-cache) between master 0 (`axi_icache` memory side) and master 1 (LSU/D-side port). It serialises whole transactions: exactly one read burst or one write burst is in flight at the slave at any time. Requests are granted round-robin, or by fixed priority when built with the configuration macro below. It sits between the cache/LSU memory ports and the memory model or SoC bus in both the core and the formal harness.

## Interface
- `CPU_WIDTH`, from `defines.vh`: address and data width.
- `ID_WIDTH`, default 4: AXI ID width, passed through unchanged.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_axi_{awvalid,awaddr,awid,awlen,awsize,awburst}`  in  1/CPU_WIDTH/ID_WIDTH/8/3/2  master 0 AW; `m0_axi_awready` out 1.
- `m0_axi_{wvalid,wdata,wstrb,wlast}`  in  1/CPU_WIDTH/CPU_WIDTH/8/1  master 0 W; `m0_axi_wready` out 1.
- `m0_axi_{bvalid,bresp,bid}`  out  1/2/ID_WIDTH  master 0 B; `m0_axi_bready` in 1.
- `m0_axi_{arvalid,araddr,arid,arlen,arsize,arburst}`  in  same widths as AW  master 0 AR; `m0_axi_arready` out 1.
- `m0_axi_{rvalid,rresp,rdata,rlast,rid}`  out  1/2/CPU_WIDTH/1/ID_WIDTH  master 0 R; `m0_axi_rready` in 1.
- `m1_axi_*`: same port set as `m0_axi_*`, for master 1.
- `s_axi_*`: mirror of the master port set with directions reversed, toward the slave.

## Operation
- FSM states:
  - `IDLE`: no grant.
  - `RD`: AR and R channels of the granted master are connected to the slave.
  - `WR`: AW, W and B channels of the granted master are connected to the slave.
- Registers: `grant` (1 bit, master index) and `last` (master granted most recently).
- Request definition: `req[i] = mi_axi_arvalid | mi_axi_awvalid`, sampled only in `IDLE`.
- Master selection in `IDLE`, when any request is asserted:
  - Round-robin: if both masters request, pick `~last`; otherwise pick the single requester.
  - Within the chosen master, AR wins over AW when both are valid.
  - Register `grant`, move to `RD` or `WR`.
- `RD`:
  - The granted master's AR/R signals are wired combinationally to `s_axi_ar*`/`s_axi_r*`.
  - Exit on `s_axi_rvalid & s_axi_rready & s_axi_rlast`: go to `IDLE`, set `last <= grant`.
- `WR`:
  - The granted master's AW/W/B signals are wired to the slave.
  - W beats may precede or follow the AW handshake.
  - Exit on `s_axi_bvalid & s_axi_bready`: go to `IDLE`, set `last <= grant`.
- Non-granted master, and both masters in `IDLE`:
  - All `*ready` and `*valid` outputs are 0; data, ID and resp outputs are 0.
- Slave side in `IDLE`: every `s_axi_*valid` and `s_axi_*ready` output is 0.
- AR/AW of the granted transaction are handshaken exactly once. After the handshake, further `arvalid`/`awvalid` from the granted master are blocked (`arready`/`awready` forced to 0) until the state returns to `IDLE`.
- Slave channels of the inactive direction (AW/W/B in `RD`, AR/R in `WR`) stay 0.
- A master that deasserts valid before ready violates AXI; behaviour in that case is undefined and is not checked.

## Timing
- Reset values: state `IDLE`, `grant = 0`, `last = 1` (so master 0 wins the first tie). Every output is 0.
- Grant latency: request visible in cycle N → slave valid in cycle N+1. Only the grant register is in the path.
- Return to `IDLE`:
  - In the cycle after the final R or B handshake.
  - The next grant appears one cycle later, so there is at least one bubble cycle between transactions.
- Data paths (R, W, B beats) are purely combinational through the arbiter: zero added latency per beat.
- Simultaneous requests on the same cycle: round-robin alternates strictly, with no starvation. Worst-case wait is one full transaction of the other master.
- Reset asserted mid-burst: state goes to `IDLE` on the next edge and all outputs read 0. The slave is reset by the same `reset`.

## Configuration
- Macro: `AXI_ARB_FIXED_PRIO_EN`.
- Defined: master 0 (I-cache) always wins a tie; `last` is not used.
- Undefined: round-robin as described above.
- In both builds, AR-before-AW within a master is unchanged.

## Structure
- Package `axi_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t`.
  - `typedef logic mst_idx_t`.
  - `localparam NUM_MST = 2`.
- Sub-module `rr_arb2`:
  - Inputs: `req[1:0]`, `last`. Output: `grant`.
  - Contains the `AXI_ARB_FIXED_PRIO_EN` selection logic.
  - Purely combinational.
- Top level: FSM plus channel muxes.

## Test plan
Memory under test is `axi_ram`, ADDR_WIDTH 8, initialised with `mem[j]=j`.
- Master 0 single read, `araddr=0x10`, `arlen=0` → `m0_axi_rdata=4` with `rlast=1`; master 1 ready/valid outputs stay 0 throughout.
- Master 1 write `0x20`, data `0xDEADBEEF`, `wstrb=0xF`, W issued 2 cycles before AW → `m1_axi_bresp=0`; a following master 0 read of `0x20` returns `0xDEADBEEF`.
- Both masters `arvalid` in the same cycle right after reset → master 0 served first, master 1 second; swapped order on the next tie.
- Master 0 burst read `0x00`, `arlen=3`, INCR, with master 1 `arvalid` held high → master 0 receives 0,1,2,3 before any master 1 `arready`; master 1 granted 2 cycles after master 0's `rlast` handshake.
- Master 0 with both `arvalid` and `awvalid` asserted → read completes first, write granted afterwards.
- Reset asserted during beat 2 of an `arlen=3` read → all outputs 0 the next cycle; a fresh master 1 read of `0x04` after reset returns 1.
- Build with `AXI_ARB_FIXED_PRIO_EN`, 4 back-to-back ties → master 0 wins all 4.
